// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among NUM_REQ requesters,
// with bounded per-grant bursts and a watchdog on the UART completion handshake.
module uart_tx_sched #(
   parameter int NUM_REQ     = 4,
   parameter int MAX_BURST   = 16,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     ack,
   output logic [7:0]             uart_data,
   output logic                   uart_start,
   input  logic                   uart_done,
   output logic                   busy,
   output logic                   timeout_err
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IW:0]  NR  = (IW+1)'(NUM_REQ);
   localparam logic [IW:0]  ONE = (IW+1)'(1);
   localparam logic [7:0]   MB  = 8'(MAX_BURST);
   localparam logic [15:0]  TO1 = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      sel_q, sel_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [7:0]         data_q, data_d;
   logic               last_q, last_d;
   logic [7:0]         burst_q, burst_d;
   logic [15:0]        wdog_q, wdog_d;

   logic [7:0]         req_byte [NUM_REQ];
   logic               hit;
   logic [IW-1:0]      hit_idx;
   logic [IW:0]        idx;
   logic [IW:0]        ptr_wrap;
   logic [IW-1:0]      ptr_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_byte[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   // Walk offsets from the far end so the requester nearest ptr wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr_q} + (IW+1)'(k);
         if (idx >= NR) idx = idx - NR;
         if (req[idx[IW-1:0]]) begin
            hit     = 1'b1;
            hit_idx = idx[IW-1:0];
         end
      end
      ptr_wrap = {1'b0, sel_q} + ONE;
      if (ptr_wrap >= NR) ptr_wrap = '0;
      ptr_nxt = ptr_wrap[IW-1:0];
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      data_d      = data_q;
      last_d      = last_q;
      burst_d     = burst_q;
      wdog_d      = wdog_q;
      uart_start  = 1'b0;
      ack         = '0;
      timeout_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               sel_d            = hit_idx;
               data_d           = req_byte[hit_idx];
               last_d           = req_last[hit_idx];
               grant_d          = '0;
               grant_d[hit_idx] = 1'b1;
               burst_d          = '0;
               state_d          = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            uart_start = 1'b1;
            ack        = grant_q;
            burst_d    = burst_q + 8'd1;
            wdog_d     = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_q + 16'd1;
            // Completion takes priority over a watchdog expiry in the same cycle.
            if (uart_done) begin
               if (!last_q && req[sel_q] && (burst_q < MB)) begin
                  data_d  = req_byte[sel_q];
                  last_d  = req_last[sel_q];
                  state_d = S_LAUNCH;
               end else begin
                  grant_d = '0;
                  ptr_d   = ptr_nxt;
                  state_d = S_IDLE;
               end
            end else if (wdog_q == TO1) begin
               timeout_err = 1'b1;
               grant_d     = '0;
               ptr_d       = ptr_nxt;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         grant_q <= '0;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
         burst_q <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         wdog_q  <= wdog_d;
      end
   end

   assign grant     = grant_q;
   assign uart_data = data_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: two instances (MAX_BURST 16 and 2) with requester
// and UART behavioural models; each launch is matched against a predicted queue entry.
module tb_uart_tx_sched;
   localparam int TO_CYC = 50;

   typedef struct {
      int         g;
      logic [7:0] d;
      int         gap;
      bit         to;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      bit         last;
   } rb_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   bit   done_en;
   bit   spur;
   int   uart_dly;

   logic [3:0]  req_s   [2];
   logic [31:0] rdata_s [2];
   logic [3:0]  rlast_s [2];
   logic        udone_s [2];
   logic [3:0]  grant_w [2];
   logic [3:0]  ack_w   [2];
   logic [7:0]  udata_w [2];
   logic        ustart_w[2];
   logic        busy_w  [2];
   logic        terr_w  [2];

   exp_t exp_q [2][$];
   rb_t  rq    [8][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   task automatic push_req(input int d, input int i, input logic [7:0] b, input bit last);
      rb_t e;
      e.d = b;
      e.last = last;
      rq[d*4+i].push_back(e);
   endtask

   task automatic push_exp(input int d, input int g, input logic [7:0] b, input int gap, input bit to);
      exp_t e;
      e.g = g;
      e.d = b;
      e.gap = gap;
      e.to = to;
      exp_q[d].push_back(e);
   endtask

   function automatic bit rq_pending(input int d);
      bit p = 1'b0;
      for (int i = 0; i < 4; i++) if (rq[d*4+i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_idle(input int d);
      int n = 0;
      while ((exp_q[d].size() != 0 || busy_w[d] || rq_pending(d)) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", 32'(n < 3000), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         uart_tx_sched #(
            .NUM_REQ    (4),
            .MAX_BURST  ((gi == 0) ? 16 : 2),
            .TIMEOUT_CYC(TO_CYC)
         ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .req        (req_s[gi]),
            .req_data   (rdata_s[gi]),
            .req_last   (rlast_s[gi]),
            .grant      (grant_w[gi]),
            .ack        (ack_w[gi]),
            .uart_data  (udata_w[gi]),
            .uart_start (ustart_w[gi]),
            .uart_done  (udone_s[gi]),
            .busy       (busy_w[gi]),
            .timeout_err(terr_w[gi])
         );

         exp_t cur;
         bit   cur_v;
         int   start_cyc;
         int   cnt;
         int   last_evt;

         always @(negedge clk) begin : p_model
            rb_t        rb;
            logic [3:0]  nr;
            logic [31:0] nd;
            logic [3:0]  nl;
            if (!reset_n) begin
               cnt   = 0;
               cur_v = 1'b0;
            end
            // UART model: tx_done a fixed delay after each start
            udone_s[gi] = spur && (gi == 0);
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0 && done_en) udone_s[gi] = 1'b1;
            end
            if (reset_n && ustart_w[gi]) cnt = uart_dly;
            // requester model: next byte presented after ack
            for (int i = 0; i < 4; i++)
               if (ack_w[gi][i] && rq[gi*4+i].size() > 0) rb = rq[gi*4+i].pop_front();
            nr = '0;
            nd = '0;
            nl = '0;
            for (int i = 0; i < 4; i++) begin
               if (rq[gi*4+i].size() > 0) begin
                  rb = rq[gi*4+i][0];
                  nr[i] = 1'b1;
                  nd[8*i +: 8] = rb.d;
                  nl[i] = rb.last;
               end
            end
            if (req_s[gi] == 4'b0 && nr != 4'b0 && !busy_w[gi]) last_evt = cyc;
            req_s[gi]   = nr;
            rdata_s[gi] = nd;
            rlast_s[gi] = nl;
            #1;
            if (reset_n) begin
               if (ustart_w[gi]) begin
                  if (exp_q[gi].size() == 0) begin
                     chk("unexpected_start", 32'd1, 32'd0);
                  end else begin
                     cur = exp_q[gi].pop_front();
                     cur_v = 1'b1;
                     start_cyc = cyc;
                     $display("[TB] dut%0d launch grant=%b ack=%b data=%02h", gi, grant_w[gi], ack_w[gi], udata_w[gi]);
                     chk("data", 32'(udata_w[gi]), 32'(cur.d));
                     chk("grant", 32'(grant_w[gi]), 32'd1 << cur.g);
                     chk("ack", 32'(ack_w[gi]), 32'd1 << cur.g);
                     chk("gap", cyc - last_evt, cur.gap);
                  end
               end
               if (terr_w[gi] && !cur_v) chk("spurious_timeout", 32'd1, 32'd0);
               if (cur_v && (udone_s[gi] || terr_w[gi])) begin
                  chk("end_kind", 32'(terr_w[gi]), 32'(cur.to));
                  chk("end_grant", 32'(grant_w[gi]), 32'd1 << cur.g);
                  if (terr_w[gi]) chk("timeout_delay", cyc - start_cyc, TO_CYC);
                  cur_v = 1'b0;
               end
               if (udone_s[gi] || terr_w[gi]) last_evt = cyc;
            end
         end
      end
   endgenerate

   task automatic chk_reset_vals(input int d, input string tag);
      chk({tag, "_grant"}, 32'(grant_w[d]), 32'd0);
      chk({tag, "_ack"}, 32'(ack_w[d]), 32'd0);
      chk({tag, "_start"}, 32'(ustart_w[d]), 32'd0);
      chk({tag, "_data"}, 32'(udata_w[d]), 32'd0);
      chk({tag, "_busy"}, 32'(busy_w[d]), 32'd0);
      chk({tag, "_terr"}, 32'(terr_w[d]), 32'd0);
   endtask

   initial begin
      int n;
      reset_n  = 1'b0;
      done_en  = 1'b1;
      spur     = 1'b0;
      uart_dly = 4;
      repeat (3) @(negedge clk);
      chk_reset_vals(0, "rst0");
      chk_reset_vals(1, "rst1");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // contention from ptr=0, requester 0 re-requests
      push_req(0, 0, 8'h10, 1); push_req(0, 1, 8'h11, 1);
      push_req(0, 2, 8'h12, 1); push_req(0, 3, 8'h13, 1);
      push_req(0, 0, 8'h14, 1);
      push_exp(0, 0, 8'h10, 1, 0); push_exp(0, 1, 8'h11, 2, 0);
      push_exp(0, 2, 8'h12, 2, 0); push_exp(0, 3, 8'h13, 2, 0);
      push_exp(0, 0, 8'h14, 2, 0);
      wait_idle(0);

      // single requester 1
      push_req(0, 1, 8'hAB, 1);
      push_exp(0, 1, 8'hAB, 1, 0);
      wait_idle(0);

      // burst on 2 (ptr=2 beats pending 1), then 3 (ptr=3), then 1
      push_req(0, 1, 8'h55, 1);
      push_req(0, 2, 8'h01, 0); push_req(0, 2, 8'h02, 0); push_req(0, 2, 8'h03, 1);
      push_req(0, 3, 8'h33, 1);
      push_exp(0, 2, 8'h01, 1, 0); push_exp(0, 2, 8'h02, 1, 0);
      push_exp(0, 2, 8'h03, 1, 0); push_exp(0, 3, 8'h33, 2, 0);
      push_exp(0, 1, 8'h55, 2, 0);
      wait_idle(0);

      // tx_done while idle is ignored
      @(posedge clk); #2 spur = 1'b1;
      @(posedge clk); #2 spur = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_done_busy", 32'(busy_w[0]), 32'd0);
      chk("idle_done_grant", 32'(grant_w[0]), 32'd0);

      // watchdog: two aborts, arbitration continues to next requester
      done_en = 1'b0;
      push_req(0, 2, 8'h77, 1); push_req(0, 0, 8'h88, 1);
      push_exp(0, 2, 8'h77, 1, 1); push_exp(0, 0, 8'h88, 2, 1);
      wait_idle(0);
      done_en = 1'b1;

      // tx_done in the same cycle the watchdog would expire
      uart_dly = TO_CYC;
      push_req(0, 2, 8'h99, 1);
      push_exp(0, 2, 8'h99, 1, 0);
      wait_idle(0);
      uart_dly = 4;

      // reset in the middle of WAIT
      push_req(0, 1, 8'h44, 1);
      push_exp(0, 1, 8'h44, 1, 0);
      n = 0;
      while (exp_q[0].size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reset_wait_launch", 32'(n < 200), 32'd1);
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1 chk_reset_vals(0, "midrst");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      push_req(0, 0, 8'hA0, 1); push_req(0, 3, 8'hA3, 1);
      push_exp(0, 0, 8'hA0, 1, 0); push_exp(0, 3, 8'hA3, 2, 0);
      wait_idle(0);

      // MAX_BURST=2 instance: requester 0 never marks last
      push_req(1, 0, 8'hC0, 0); push_req(1, 0, 8'hC1, 0);
      push_req(1, 0, 8'hC2, 0); push_req(1, 0, 8'hC3, 0);
      push_req(1, 1, 8'hD0, 1);
      push_exp(1, 0, 8'hC0, 1, 0); push_exp(1, 0, 8'hC1, 1, 0);
      push_exp(1, 1, 8'hD0, 2, 0); push_exp(1, 0, 8'hC2, 2, 0);
      push_exp(1, 0, 8'hC3, 1, 0);
      wait_idle(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
